multiplier_control: RTL and testbench

//  Sequencing FSM for the 8-bit signed shift-add multiplier datapath (accumulator A/X, multiplier B).

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_iter_counter.sv | 35 +++
 rtl/multiplier_control.sv | 99 +++++++++
 tb/tb_multiplier_control.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing for the shift-add multiplier control path.
package mult_pkg;

   localparam int MULT_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      ADD   = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } mult_state_t;

   typedef logic [$clog2(MULT_WIDTH):0] mult_count_t;

endpackage

// File: rtl/mult_iter_counter.sv
// Iteration counter for the multiplier FSM: cleared at start, bumped once per shift.
module mult_iter_counter
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   localparam int CW = $clog2(WIDTH) + 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic last
);

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clr)
         count_d = '0;
      else if (inc)
         count_d = count_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count_q <= '0;
      else
         count_q <= count_d;
   end

   // last marks the sign-bit iteration; in SHIFT it also means count+1 == WIDTH
   assign last = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/multiplier_control.sv
// Sequencing FSM for the 8-bit signed shift-add multiplier register unit.
// Optional MULT_AUTO_CLEAR_EN inserts a CLR state so every Run starts from A/X = 0.
module multiplier_control
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic Clk,
   input  logic Reset_n,
   input  logic Run,
   input  logic ClearA_LoadB,
   input  logic M,
   output logic Clear_En,
   output logic Load,
   output logic Add_En,
   output logic Sub_En,
   output logic Shift_En,
   output logic Busy,
   output logic Done
);

   mult_state_t state_q, state_d;
   logic        cnt_clr;
   logic        cnt_inc;
   logic        cnt_last;

   mult_iter_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk   (Clk),
      .rst_n (Reset_n),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .last  (cnt_last)
   );

   assign cnt_inc = (state_q == SHIFT);

   always_comb begin
      state_d = state_q;
      cnt_clr = 1'b0;
      case (state_q)
         IDLE: begin
            // a clear/load request takes the cycle; Run waits for the next one
            if (Run && !ClearA_LoadB) begin
               cnt_clr = 1'b1;
`ifdef MULT_AUTO_CLEAR_EN
               state_d = CLR;
`else
               state_d = ADD;
`endif
            end
         end
         CLR:     state_d = ADD;
         ADD:     state_d = SHIFT;
         SHIFT:   state_d = cnt_last ? DONE : ADD;
         DONE:    if (!Run) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      Clear_En = 1'b0;
      Load     = 1'b0;
      Add_En   = 1'b0;
      Sub_En   = 1'b0;
      Shift_En = 1'b0;
      Busy     = 1'b0;
      Done     = 1'b0;
      case (state_q)
         IDLE: begin
            // gated by reset so every output is quiet while Reset_n is low
            Clear_En = ClearA_LoadB & Reset_n;
            Load     = ClearA_LoadB & Reset_n;
         end
         CLR: begin
            Clear_En = 1'b1;
            Busy     = 1'b1;
         end
         ADD: begin
            Add_En = M & ~cnt_last;
            Sub_En = M &  cnt_last;
            Busy   = 1'b1;
         end
         SHIFT: begin
            Shift_En = 1'b1;
            Busy     = 1'b1;
         end
         DONE:    Done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multiplier_control.sv
// Directed bench for multiplier_control with a small A/X/B register-unit model for end-to-end products.
module tb_multiplier_control;

`ifdef MULT_AUTO_CLEAR_EN
   localparam int AUTO = 1;
`else
   localparam int AUTO = 0;
`endif

   logic Clk, Reset_n, Run, ClearA_LoadB, M;
   logic Clear_En, Load, Add_En, Sub_En, Shift_En, Busy, Done;

   logic       use_model, m_drv;
   logic [7:0] D;
   logic [7:0] a_q, b_q;
   logic       x_q;
   logic [8:0] sum;

   int checks = 0;
   int errors = 0;

   multiplier_control dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .Run          (Run),
      .ClearA_LoadB (ClearA_LoadB),
      .M            (M),
      .Clear_En     (Clear_En),
      .Load         (Load),
      .Add_En       (Add_En),
      .Sub_En       (Sub_En),
      .Shift_En     (Shift_En),
      .Busy         (Busy),
      .Done         (Done)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   assign M = use_model ? b_q[0] : m_drv;

   // register unit: 9-bit signed add/sub into {X,A}, arithmetic shift of {X,A,B}
   always_comb begin
      sum = {a_q[7], a_q};
      if (Add_En) sum = {a_q[7], a_q} + {D[7], D};
      if (Sub_En) sum = {a_q[7], a_q} - {D[7], D};
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         a_q <= 8'h00; b_q <= 8'h00; x_q <= 1'b0;
      end else begin
         if (Clear_En) begin a_q <= 8'h00; x_q <= 1'b0; end
         if (Load) b_q <= D;
         if (Add_En || Sub_En) begin x_q <= sum[8]; a_q <= sum[7:0]; end
         if (Shift_En) begin a_q <= {x_q, a_q[7:1]}; b_q <= {a_q[0], b_q[7:1]}; end
      end
   end

   wire [6:0] obs = {Clear_En, Load, Add_En, Sub_En, Shift_En, Busy, Done};

   // expected {Clear_En,Load,Add_En,Sub_En,Shift_En,Busy,Done} c cycles after Run accept
   function automatic logic [6:0] exp_vec(input int c, input logic m);
      int k;
      logic [6:0] v;
      v = 7'b0;
      if (AUTO == 1 && c == 0) return 7'b1000010;
      k = c - AUTO;
      if (k >= 16) v[0] = 1'b1;
      else begin
         v[1] = 1'b1;
         if (k % 2 == 1) v[2] = 1'b1;
         else if (k == 14) v[3] = m;
         else v[4] = m;
      end
      return v;
   endfunction

   task automatic run_and_check(input string name, input logic mval, input bit hold_run);
      @(negedge Clk);
      m_drv = mval; Run = 1'b1;
      @(posedge Clk);
      for (int c = 0; c <= 16 + AUTO; c++) begin
         @(negedge Clk);
         if (!hold_run) Run = 1'b0;
         ClearA_LoadB = (c == 3 || c == 16 + AUTO);
         #1;
         checks++;
         if (obs !== exp_vec(c, mval)) begin
            errors++;
            $display("FAIL %s cyc %0d: got %b want %b", name, c, obs, exp_vec(c, mval));
         end
      end
      ClearA_LoadB = 1'b0;
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; Run = 1'b0; ClearA_LoadB = 1'b0; m_drv = 1'b0; use_model = 1'b0; D = 8'h00;
      #12;
      checks++;
      if (obs !== 7'b0) begin errors++; $display("FAIL reset_outs: got %b want 0000000", obs); end
      @(negedge Clk); Reset_n = 1'b1;
      @(negedge Clk); #1;
      checks++;
      if (obs !== 7'b0) begin errors++; $display("FAIL reset_idle: got %b want 0000000", obs); end
   endtask

   task automatic test_clear_load();
      @(negedge Clk);
      ClearA_LoadB = 1'b1; Run = 1'b1; #1;
      checks++;
      if (obs !== 7'b1100000) begin errors++; $display("FAIL clr_load: got %b want 1100000", obs); end
      @(negedge Clk);
      ClearA_LoadB = 1'b0; Run = 1'b0; #1;
      checks++;
      if (obs !== 7'b0) begin errors++; $display("FAIL clr_wins_run: got %b want 0000000", obs); end
   endtask

   task automatic test_m_one();
      run_and_check("m_one", 1'b1, 1'b0);
   endtask

   task automatic test_m_zero();
      run_and_check("m_zero", 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      @(negedge Clk);
      @(negedge Clk);
      m_drv = 1'b1; Run = 1'b1;
      @(posedge Clk);
      for (int c = 0; c <= 6 + AUTO; c++) begin
         @(negedge Clk); Run = 1'b0; #1;
         checks++;
         if (obs !== exp_vec(c, 1'b1)) begin
            errors++; $display("FAIL pre_reset cyc %0d: got %b want %b", c, obs, exp_vec(c, 1'b1));
         end
      end
      Reset_n = 1'b0; #1;
      checks++;
      if (obs !== 7'b0) begin errors++; $display("FAIL mid_reset: got %b want 0000000", obs); end
      @(negedge Clk); Reset_n = 1'b1;
      @(negedge Clk); #1;
      checks++;
      if (obs !== 7'b0) begin errors++; $display("FAIL post_reset_idle: got %b want 0000000", obs); end
      run_and_check("restart", 1'b1, 1'b0);
   endtask

   task automatic test_back_to_back();
      @(negedge Clk);
      run_and_check("hold_run", 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk); #1;
         checks++;
         if (obs !== 7'b0000001) begin errors++; $display("FAIL done_hold %0d: got %b want 0000001", i, obs); end
      end
      Run = 1'b0; #1;
      checks++;
      if (obs !== 7'b0000001) begin errors++; $display("FAIL done_run_low: got %b want 0000001", obs); end
      @(negedge Clk); #1;
      checks++;
      if (obs !== 7'b0) begin errors++; $display("FAIL back_idle: got %b want 0000000", obs); end
      run_and_check("second", 1'b0, 1'b0);
   endtask

   task automatic do_product(input string name, input logic [7:0] s, input logic [7:0] b,
                             input logic [15:0] want);
      bit seen;
      @(negedge Clk);
      @(negedge Clk);
      use_model = 1'b1; D = b; ClearA_LoadB = 1'b1;
      @(negedge Clk);
      ClearA_LoadB = 1'b0; D = s; Run = 1'b1;
      @(negedge Clk);
      Run = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         #1;
         if (Done) seen = 1'b1;
         else @(negedge Clk);
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL %s_done: got 0 want 1 within 40 cycles", name); end
      checks++;
      if ({a_q, b_q} !== want) begin
         errors++; $display("FAIL %s_product: got %h want %h", name, {a_q, b_q}, want);
      end
      use_model = 1'b0;
   endtask

   task automatic test_products();
      do_product("p7xm3", 8'h07, 8'hFD, 16'hFFEB);
      do_product("p80x80", 8'h80, 8'h80, 16'h4000);
   endtask

   initial begin
      test_reset();
      test_clear_load();
      test_m_one();
      test_m_zero();
      test_reset_mid();
      test_back_to_back();
      test_products();
      @(negedge Clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
